regfile_write_sequencer: RTL and testbench

Write-side initiator for the 16×32 CPU register file. Collects register write-back requests from two producers (ALU result path and memory load path), orders them in a small FIFO, and issues exactly one register file write per cycle on the register file's `regWrite`/`A3`/`WD3` port. It also publishes a per-register pending-write mask so decode can stall reads of registers whose write is still in flight.

---
 rtl/regfile_write_sequencer.sv | 131 +++++++++++++
 tb/tb_regfile_write_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-side sequencer for the 16x32 register file: merges load and ALU write-backs
// through a small FIFO and issues one registered write per cycle with a pending-write mask.
module regfile_write_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [15:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_slot;
    logic [CW-1:0]     count_q, count_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              mem_acc, alu_acc, pop;

    // Readys look only at the current occupancy; the load path owns the last free slot.
    always_comb begin
        mem_ready = rst && (count_q < CW'(DEPTH));
        alu_ready = rst && ((count_q <= CW'(DEPTH - 2)) ||
                            ((count_q == CW'(DEPTH - 1)) && !mem_valid));
        mem_acc   = mem_valid && mem_ready;
        alu_acc   = alu_valid && alu_ready;
        pop       = (count_q != '0);
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        rd_ptr_d   = rd_ptr_q;
        wr_slot    = wr_ptr_q;
        regwrite_d = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;

        if (pop) begin
            regwrite_d        = 1'b1;
            a3_d              = addr_q[rd_ptr_q];
            wd3_d             = data_q[rd_ptr_q];
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end

        // Load entry goes in first so it is older than a same-cycle ALU entry.
        if (mem_acc) begin
            valid_d[wr_slot] = 1'b1;
            addr_d[wr_slot]  = mem_addr;
            data_d[wr_slot]  = mem_data;
            wr_slot          = wr_slot + PW'(1);
        end
        if (alu_acc) begin
            valid_d[wr_slot] = 1'b1;
            addr_d[wr_slot]  = alu_addr;
            data_d[wr_slot]  = alu_data;
            wr_slot          = wr_slot + PW'(1);
        end

        wr_ptr_d = wr_slot;
        count_d  = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < 16; r++) begin
            if (regwrite_q && (a3_q == ADDR_W'(r))) begin
                pending[r] = 1'b1;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (addr_q[i] == ADDR_W'(r))) begin
                    pending[r] = 1'b1;
                end
            end
        end
    end

    assign regWrite = regwrite_q;
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign count    = count_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed vector table plus scoreboard-checked traffic, wrap-around and mid-operation reset.
module tb_regfile_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_addr, alu_addr;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        regWrite;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [15:0] pending;
    logic [2:0]  count;

    regfile_write_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .regWrite  (regWrite),
        .A3        (A3),
        .WD3       (WD3),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        emr;
        logic        ear;
        logic        erw;
        logic [3:0]  ea3;
        logic [31:0] ewd;
        logic [15:0] epend;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[19];

    // Reference model state
    logic [3:0]  mq_addr[$];
    logic [31:0] mq_data[$];
    logic        m_rw;
    logic [3:0]  m_a3;
    logic [31:0] m_wd3;
    int          n_acc, n_ret;

    task automatic model_clear();
        mq_addr.delete();
        mq_data.delete();
        m_rw  = 1'b0;
        m_a3  = 4'd0;
        m_wd3 = 32'd0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        mem_addr  = 4'd0;
        alu_addr  = 4'd0;
        mem_data  = 32'd0;
        alu_data  = 32'd0;
        #3;
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_A3", 32'(A3), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    // One clock of stimulus, checked against the queue model.
    task automatic cycle(input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic av, input logic [3:0] aa, input logic [31:0] ad);
        int          cnt;
        logic        emr, ear;
        logic [15:0] epend;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        #1;
        cnt = mq_addr.size();
        emr = (cnt < 4);
        ear = (cnt <= 2) || (cnt == 3 && !mv);
        chk("sb_mem_ready", 32'(mem_ready), 32'(emr));
        chk("sb_alu_ready", 32'(alu_ready), 32'(ear));
        @(posedge clk);
        if (cnt > 0) begin
            m_rw  = 1'b1;
            m_a3  = mq_addr.pop_front();
            m_wd3 = mq_data.pop_front();
            n_ret++;
        end else begin
            m_rw = 1'b0;
        end
        if (mv && emr) begin mq_addr.push_back(ma); mq_data.push_back(md); n_acc++; end
        if (av && ear) begin mq_addr.push_back(aa); mq_data.push_back(ad); n_acc++; end
        #1;
        epend = '0;
        foreach (mq_addr[k]) epend[mq_addr[k]] = 1'b1;
        if (m_rw) epend[m_a3] = 1'b1;
        chk("sb_regWrite", 32'(regWrite), 32'(m_rw));
        chk("sb_A3", 32'(A3), 32'(m_a3));
        chk("sb_WD3", WD3, m_wd3);
        chk("sb_count", 32'(count), 32'(mq_addr.size()));
        chk("sb_pending", 32'(pending), 32'(epend));
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        //          mv    ma     md            av    aa     ad            mr    ar    rw    a3     wd3           pend      cnt
        vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b0, 4'd0,  32'h0,        16'h0020, 3'd1};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd5,  32'hDEADBEEF, 16'h0020, 3'd0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b0, 4'd5,  32'hDEADBEEF, 16'h0000, 3'd0};
        vecs[3]  = '{1'b1, 4'd3,  32'h11,       1'b1, 4'd3,  32'h22,      1'b1, 1'b1, 1'b0, 4'd5,  32'hDEADBEEF, 16'h0008, 3'd2};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd3,  32'h11,       16'h0008, 3'd1};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd3,  32'h22,       16'h0008, 3'd0};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b0, 4'd3,  32'h22,       16'h0000, 3'd0};
        vecs[7]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b1, 4'd0,  32'h1,       1'b1, 1'b1, 1'b0, 4'd3,  32'h22,       16'h8001, 3'd2};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd15, 32'hFFFFFFFF, 16'h8001, 3'd1};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd0,  32'h1,        16'h0001, 3'd0};
        vecs[10] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b0, 4'd0,  32'h1,        16'h0000, 3'd0};
        vecs[11] = '{1'b1, 4'd1,  32'h100,      1'b1, 4'd2,  32'h200,     1'b1, 1'b1, 1'b0, 4'd0,  32'h1,        16'h0006, 3'd2};
        vecs[12] = '{1'b1, 4'd3,  32'h300,      1'b1, 4'd4,  32'h400,     1'b1, 1'b1, 1'b1, 4'd1,  32'h100,      16'h001E, 3'd3};
        vecs[13] = '{1'b1, 4'd5,  32'h500,      1'b1, 4'd6,  32'h600,     1'b1, 1'b0, 1'b1, 4'd2,  32'h200,      16'h003C, 3'd3};
        vecs[14] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  32'h600,     1'b1, 1'b1, 1'b1, 4'd3,  32'h300,      16'h0078, 3'd3};
        vecs[15] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd4,  32'h400,      16'h0070, 3'd2};
        vecs[16] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd5,  32'h500,      16'h0060, 3'd1};
        vecs[17] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b1, 4'd6,  32'h600,      16'h0040, 3'd0};
        vecs[18] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,       1'b1, 1'b1, 1'b0, 4'd6,  32'h600,      16'h0000, 3'd0};

        n_acc = 0;
        n_ret = 0;
        do_reset();

        foreach (vecs[i]) begin
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            #1;
            chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].erw));
            chk($sformatf("v%0d_A3", i), 32'(A3), 32'(vecs[i].ea3));
            chk($sformatf("v%0d_WD3", i), WD3, vecs[i].ewd);
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].epend));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
        end

        // Continuous traffic on both producers.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'(2 * i), 32'h1000 + 32'(2 * i),
                  1'b1, 4'(2 * i + 1), 32'h1000 + 32'(2 * i + 1));
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        chk("traffic_acc_vs_ret", 32'(n_ret), 32'(n_acc));

        // Alternating single requests through the 4-entry ring.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) cycle(1'b1, 4'(i), 32'hA0 + 32'(i), 1'b0, 4'd0, 32'd0);
            else            cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 32'hA0 + 32'(i));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        chk("wrap_count_end", 32'(count), 32'd0);
        chk("wrap_pending_end", 32'(pending), 32'd0);
        chk("wrap_acc_vs_ret", 32'(n_ret), 32'(n_acc));

        // Reset between edges with three entries queued.
        cycle(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88);
        cycle(1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA);
        chk("pre_reset_count", 32'(count), 32'd3);
        mem_valid = 1'b1;
        alu_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_regWrite", 32'(regWrite), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_mem_ready", 32'(mem_ready), 32'd0);
        chk("midrst_alu_ready", 32'(alu_ready), 32'd0);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
